// File: rtl/ofdm_rx_sample_pacer_if.sv
// Sample-pair stream bundle for the OFDM RX pacer: push side (in_*) and
// paced output side (rx_*).
interface ofdm_rx_sample_pacer_if #(
   parameter int unsigned sample_bit_width_g = 12
);
   logic [sample_bit_width_g-1:0] in_i;
   logic [sample_bit_width_g-1:0] in_q;
   logic                          in_valid;
   logic                          in_ready;
   logic [sample_bit_width_g-1:0] rx_data_i;
   logic [sample_bit_width_g-1:0] rx_data_q;
   logic                          rx_data_valid;

   // Producer / consumer side of the pacer
   modport master (
      output in_i, in_q, in_valid,
      input  in_ready, rx_data_i, rx_data_q, rx_data_valid
   );

   // The pacer itself
   modport slave (
      input  in_i, in_q, in_valid,
      output in_ready, rx_data_i, rx_data_q, rx_data_valid
   );
endinterface

// File: rtl/ofdm_rx_sample_pacer.sv
// OFDM RX sample pacer: buffers I/Q pairs in a FIFO and releases one pair
// per programmable strobe period once the FIFO has been primed.
module ofdm_rx_sample_pacer #(
   parameter int unsigned sample_bit_width_g = 12,
   parameter int unsigned fifo_depth_g       = 64,
   parameter int unsigned divider_width_g    = 8,
   parameter int unsigned prime_level_g      = 8
) (
   input  logic                             sys_clk,
   input  logic                             sys_rstn,
   input  logic                             sys_init,
   input  logic                             en,
   input  logic [divider_width_g-1:0]       cfg_divider,
   ofdm_rx_sample_pacer_if.slave            smp,
   output logic [$clog2(fifo_depth_g):0]    fill_level,
   output logic                             overflow,
   output logic                             underflow
);

   localparam int unsigned ptr_w  = $clog2(fifo_depth_g);
   localparam int unsigned fill_w = ptr_w + 1;
   localparam int unsigned dw     = divider_width_g;
   localparam int unsigned sw     = sample_bit_width_g;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [dw-1:0]     cnt;
   logic [dw-1:0]     cnt_nxt;
   logic [dw-1:0]     div_eff;
   logic              strobe;
   logic              push;
   logic              pop;
   logic              drop;
   logic              fifo_empty;
   logic              in_ready_int;

   logic [sw-1:0]     mem_i [fifo_depth_g];
   logic [sw-1:0]     mem_q [fifo_depth_g];
   logic [ptr_w-1:0]  wr_ptr;
   logic [ptr_w-1:0]  rd_ptr;
   logic [fill_w-1:0] fill;

   logic [sw-1:0]     rx_i;
   logic [sw-1:0]     rx_q;
   logic              rx_valid;

   // Divider values 0 and 1 behave as 2
   assign div_eff      = (cfg_divider < dw'(2)) ? dw'(2) : cfg_divider;
   assign in_ready_int = (fill < fill_w'(fifo_depth_g));
   assign fifo_empty   = (fill == '0);
   assign push         = smp.in_valid && in_ready_int && !sys_init;
   assign drop         = smp.in_valid && !in_ready_int;
   assign pop          = strobe && !fifo_empty && !sys_init;

   assign smp.in_ready      = in_ready_int;
   assign smp.rx_data_i     = rx_i;
   assign smp.rx_data_q     = rx_q;
   assign smp.rx_data_valid = rx_valid;
   assign fill_level        = fill;

   // Next-state and strobe generation; >= lets a shrunk divider fire at once
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      strobe    = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = PRIME;
         end
         PRIME: begin
            if (!en)                                   state_nxt = IDLE;
            else if (fill >= fill_w'(prime_level_g))   state_nxt = RUN;
         end
         RUN: begin
            if (!en) begin
               state_nxt = IDLE;
            end else if (cnt >= div_eff - dw'(1)) begin
               strobe = 1'b1;
            end else begin
               cnt_nxt = cnt + dw'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (sys_init) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end
   end

   // State and strobe counter registers
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else if (sys_init) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ptr_w'(1);
         if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
         case ({push, pop})
            2'b10:   fill <= fill + fill_w'(1);
            2'b01:   fill <= fill - fill_w'(1);
            default: fill <= fill;
         endcase
      end
   end

   // Sample storage carries no reset; validity is tracked by the pointers
   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem_i[wr_ptr] <= smp.in_i;
         mem_q[wr_ptr] <= smp.in_q;
      end
   end

   // Paced output: data holds between pulses
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         rx_i     <= '0;
         rx_q     <= '0;
         rx_valid <= 1'b0;
      end else if (sys_init) begin
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= pop;
         if (pop) begin
            rx_i <= mem_i[rd_ptr];
            rx_q <= mem_q[rd_ptr];
         end
      end
   end

   // Sticky error flags
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (sys_init) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (drop)                 overflow  <= 1'b1;
         if (strobe && fifo_empty) underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ofdm_rx_sample_pacer.sv
// Self-checking bench for ofdm_rx_sample_pacer: queue-based reference model,
// scoreboard of expected paced pairs, and a negedge monitor.
module tb_ofdm_rx_sample_pacer;

   localparam int unsigned W     = 12;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned DW    = 8;
   localparam int unsigned PRIME = 8;

   localparam int M_IDLE  = 0;
   localparam int M_PRIME = 1;
   localparam int M_RUN   = 2;

   logic          sys_clk = 1'b0;
   logic          sys_rstn;
   logic          sys_init;
   logic          en;
   logic [DW-1:0] cfg_divider;
   logic [6:0]    fill_level;
   logic          overflow;
   logic          underflow;

   ofdm_rx_sample_pacer_if #(.sample_bit_width_g(W)) smp ();

   ofdm_rx_sample_pacer #(
      .sample_bit_width_g (W),
      .fifo_depth_g       (DEPTH),
      .divider_width_g    (DW),
      .prime_level_g      (PRIME)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rstn    (sys_rstn),
      .sys_init    (sys_init),
      .en          (en),
      .cfg_divider (cfg_divider),
      .smp         (smp),
      .fill_level  (fill_level),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct { logic [W-1:0] i; logic [W-1:0] q; } pair_t;

   // Reference model state
   pair_t          m_fifo[$];
   pair_t          exp_q[$];
   int             m_mode   = M_IDLE;
   int             m_phase  = 0;
   bit             m_ovf    = 1'b0;
   bit             m_udf    = 1'b0;
   bit             m_valid  = 1'b0;
   logic [W-1:0]   m_last_i = '0;
   logic [W-1:0]   m_last_q = '0;
   int             cyc      = 0;

   int             n_checks = 0;
   int             n_fail   = 0;
   int             pulse_cnt = 0;
   int             expected_period = 0;
   int             prev_cyc = 0;
   bit             prev_ok  = 1'b0;

   function automatic void chk(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Behavioural model: FIFO as a queue, pacing as "one pop every eff cycles in RUN"
   initial begin
      int    eff;
      int    size_pre;
      bit    strobe;
      bit    full;
      pair_t p;
      forever begin
         @(posedge sys_clk or negedge sys_rstn);
         if (!sys_rstn) begin
            m_fifo.delete();
            exp_q.delete();
            m_mode = M_IDLE; m_phase = 0;
            m_ovf = 0; m_udf = 0; m_valid = 0;
            m_last_i = '0; m_last_q = '0;
         end else begin
            cyc++;
            eff      = (int'(cfg_divider) < 2) ? 2 : int'(cfg_divider);
            size_pre = m_fifo.size();
            full     = (size_pre >= int'(DEPTH));
            strobe   = (m_mode == M_RUN) && en && (m_phase >= eff - 1);
            if (sys_init) begin
               m_fifo.delete();
               m_mode = M_IDLE; m_phase = 0;
               m_ovf = 0; m_udf = 0; m_valid = 0;
            end else begin
               m_valid = 0;
               if (strobe) begin
                  if (size_pre > 0) begin
                     p = m_fifo.pop_front();
                     m_last_i = p.i; m_last_q = p.q;
                     m_valid = 1;
                     exp_q.push_back(p);
                  end else begin
                     m_udf = 1;
                  end
               end
               if (smp.in_valid && !full) begin
                  p.i = smp.in_i; p.q = smp.in_q;
                  m_fifo.push_back(p);
               end
               if (smp.in_valid && full) m_ovf = 1;
               if (m_mode == M_RUN && en) m_phase = strobe ? 0 : m_phase + 1;
               else                       m_phase = 0;
               if (!en)                                            m_mode = M_IDLE;
               else if (m_mode == M_IDLE)                          m_mode = M_PRIME;
               else if (m_mode == M_PRIME && size_pre >= int'(PRIME)) m_mode = M_RUN;
            end
         end
      end
   end

   // Monitor: compare outputs each negedge; pop scoreboard on each pulse
   initial begin
      pair_t e;
      forever begin
         @(negedge sys_clk);
         chk("rx_data_valid", smp.rx_data_valid, m_valid);
         if (smp.rx_data_valid === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_data_i", smp.rx_data_i, e.i);
               chk("pulse_data_q", smp.rx_data_q, e.q);
            end
            if (expected_period != 0 && prev_ok)
               chk("pulse_period", cyc - prev_cyc, expected_period);
            prev_cyc = cyc;
            prev_ok  = 1'b1;
         end
         chk("rx_data_i_hold", smp.rx_data_i, m_last_i);
         chk("rx_data_q_hold", smp.rx_data_q, m_last_q);
         chk("fill_level", fill_level, m_fifo.size());
         chk("in_ready", smp.in_ready, (m_fifo.size() < int'(DEPTH)) ? 1 : 0);
         chk("overflow", overflow, m_ovf);
         chk("underflow", underflow, m_udf);
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drive_pair();
      smp.in_i = W'($urandom);
      smp.in_q = W'($urandom);
   endtask

   task automatic push_n(input int n);
      for (int k = 0; k < n; k++) begin
         smp.in_valid = 1'b1;
         drive_pair();
         step();
      end
      smp.in_valid = 1'b0;
   endtask

   task automatic do_init();
      en              = 1'b0;
      sys_init        = 1'b1;
      step();
      sys_init        = 1'b0;
      expected_period = 0;
      prev_ok         = 1'b0;
   endtask

   task automatic wait_pulses(input int target, input int budget, input string name);
      int k = 0;
      while (pulse_cnt < target && k < budget) begin
         step();
         k++;
      end
      chk(name, pulse_cnt, target);
   endtask

   initial begin
      int  base;
      bit  found;
      sys_rstn     = 1'b0;
      sys_init     = 1'b0;
      en           = 1'b0;
      cfg_divider  = DW'(4);
      smp.in_valid = 1'b0;
      smp.in_i     = '0;
      smp.in_q     = '0;
      step();
      step();
      chk("reset_in_ready", smp.in_ready, 1);
      chk("reset_fill", fill_level, 0);
      chk("reset_valid", smp.rx_data_valid, 0);
      chk("reset_rx_i", smp.rx_data_i, 0);
      chk("reset_flags", {overflow, underflow}, 0);

      // Nominal pacing, first push on the edge right after release
      base = pulse_cnt;
      expected_period = 25; prev_ok = 1'b0;
      sys_rstn = 1'b1;
      cfg_divider = DW'(25);
      en = 1'b1;
      push_n(40);
      wait_pulses(base + 40, 1200, "nominal_pulse_count");
      en = 1'b0;
      chk("nominal_underflow", underflow, 0);
      do_init();

      // Underflow after draining
      base = pulse_cnt;
      cfg_divider = DW'(4);
      expected_period = 4; prev_ok = 1'b0;
      en = 1'b1;
      push_n(8);
      wait_pulses(base + 8, 200, "underflow_pulse_count");
      repeat (6) step();
      chk("underflow_set", underflow, 1);
      chk("underflow_no_extra_pulse", pulse_cnt, base + 8);
      chk("underflow_valid_low", smp.rx_data_valid, 0);
      en = 1'b0;
      do_init();

      // Overflow with pacer disabled, then drain to confirm contents
      cfg_divider = DW'(2);
      push_n(int'(DEPTH) + 3);
      chk("overflow_in_ready", smp.in_ready, 0);
      chk("overflow_flag", overflow, 1);
      chk("overflow_fill", fill_level, DEPTH);
      base = pulse_cnt;
      expected_period = 2; prev_ok = 1'b0;
      en = 1'b1;
      wait_pulses(base + int'(DEPTH), 400, "overflow_drain_count");
      en = 1'b0;
      do_init();

      // Divider clamp (0 -> 2) then change to 10 mid-run
      base = pulse_cnt;
      cfg_divider = DW'(0);
      expected_period = 2; prev_ok = 1'b0;
      en = 1'b1;
      push_n(8);
      wait_pulses(base + 4, 100, "clamp_pulse_count");
      cfg_divider = DW'(10);
      expected_period = 10;
      wait_pulses(base + 7, 100, "divider_change_count");
      en = 1'b0;
      do_init();

      // sys_init while RUN with 20 queued; restart must re-prime
      cfg_divider = DW'(200);
      en = 1'b1;
      push_n(20);
      repeat (3) step();
      chk("init_pre_fill", fill_level, 20);
      sys_init = 1'b1;
      step();
      sys_init = 1'b0;
      chk("init_fill", fill_level, 0);
      chk("init_flags", {overflow, underflow}, 0);
      chk("init_valid", smp.rx_data_valid, 0);
      base = pulse_cnt;
      cfg_divider = DW'(4);
      push_n(3);
      repeat (30) step();
      chk("init_no_pulse_before_prime", pulse_cnt, base);
      push_n(5);
      wait_pulses(base + 8, 200, "init_reprime_count");
      en = 1'b0;
      do_init();

      // Randomized traffic, divider, enable and init
      en = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         smp.in_valid = ($urandom_range(0, 9) < 6);
         drive_pair();
         if ($urandom_range(0, 99) == 0)  cfg_divider = DW'($urandom_range(0, 7));
         if ($urandom_range(0, 199) == 0) en = ~en;
         sys_init = ($urandom_range(0, 499) == 0);
         step();
      end
      smp.in_valid = 1'b0;
      sys_init = 1'b0;
      do_init();

      // Async reset while a pulse is on the outputs
      cfg_divider = DW'(3);
      en = 1'b1;
      push_n(10);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge sys_clk);
         if (smp.rx_data_valid === 1'b1) found = 1'b1;
      end
      chk("async_setup_pulse_seen", found, 1);
      #1;
      sys_rstn = 1'b0;
      #1;
      chk("async_valid", smp.rx_data_valid, 0);
      chk("async_rx_i", smp.rx_data_i, 0);
      chk("async_rx_q", smp.rx_data_q, 0);
      chk("async_fill", fill_level, 0);
      chk("async_flags", {overflow, underflow}, 0);
      chk("async_in_ready", smp.in_ready, 1);
      step();
      step();
      base = pulse_cnt;
      sys_rstn = 1'b1;
      push_n(10);
      wait_pulses(base + 3, 100, "post_reset_reprime_count");
      en = 1'b0;
      repeat (3) step();

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
